// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register: PC, instruction-memory address, IF/ID latch.
// Optional performance counters are enabled by defining IFID_PERF_CNT_EN.
module if_id_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hazard_detected,
  input  logic             ex_branch_taken,
  input  logic [63:0]      ex_branch_target,
  output logic [63:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [63:0]      if_id_pc,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic [4:0]       if_id_Rs1,
  output logic [4:0]       if_id_Rs2,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  logic [63:0] r_pc;
  logic [63:0] r_ifIdPc;
  logic [31:0] r_ifIdInstr;
  logic        r_ifIdValid;

  // Redirect beats stall so a branch squashes even while the hazard unit is asserting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_ifIdPc    <= 64'h0;
      r_ifIdInstr <= NOP_INSTR;
      r_ifIdValid <= 1'b0;
    end else if (ex_branch_taken) begin
      r_pc        <= ex_branch_target & ~64'h3;
      r_ifIdPc    <= 64'h0;
      r_ifIdInstr <= NOP_INSTR;
      r_ifIdValid <= 1'b0;
    end else if (!hazard_detected) begin
      r_pc        <= r_pc + 64'd4;
      r_ifIdPc    <= r_pc;
      r_ifIdInstr <= imem_rdata;
      r_ifIdValid <= 1'b1;
    end
  end

  assign imem_addr   = r_pc;
  assign if_id_pc    = r_ifIdPc;
  assign if_id_instr = r_ifIdInstr;
  assign if_id_valid = r_ifIdValid;
  assign if_id_Rs1   = r_ifIdInstr[19:15];
  assign if_id_Rs2   = r_ifIdInstr[24:20];

`ifdef IFID_PERF_CNT_EN
  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;

  // Saturating counters; a stall cycle only counts when no branch overrides it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (hazard_detected && !ex_branch_taken && (r_stallCnt != '1))
        r_stallCnt <= r_stallCnt + CNT_W'(1);
      if (ex_branch_taken && (r_flushCnt != '1))
        r_flushCnt <= r_flushCnt + CNT_W'(1);
    end
  end

  assign stall_count = r_stallCnt;
  assign flush_count = r_flushCnt;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage: fetch, stall, flush, priority, wrap and reset.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        hazardDetected;
  logic        exBranchTaken;
  logic [63:0] exBranchTarget;
  logic [31:0] imemRdata;

  logic [63:0] imemAddr, ifIdPc;
  logic [31:0] ifIdInstr;
  logic        ifIdValid;
  logic [4:0]  ifIdRs1, ifIdRs2;
  logic [31:0] stallCount, flushCount;

  logic [63:0] wrapImemAddr, wrapIfIdPc;
  logic [31:0] wrapIfIdInstr;
  logic        wrapIfIdValid;
  logic [4:0]  wrapRs1, wrapRs2;
  logic [31:0] wrapStallCount, wrapFlushCount;

  int compareCount  = 0;
  int mismatchCount = 0;

`ifdef IFID_PERF_CNT_EN
  localparam bit PerfOn = 1'b1;
`else
  localparam bit PerfOn = 1'b0;
`endif

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk(clk), .reset(reset), .hazard_detected(hazardDetected),
    .ex_branch_taken(exBranchTaken), .ex_branch_target(exBranchTarget),
    .imem_addr(imemAddr), .imem_rdata(imemRdata),
    .if_id_pc(ifIdPc), .if_id_instr(ifIdInstr), .if_id_valid(ifIdValid),
    .if_id_Rs1(ifIdRs1), .if_id_Rs2(ifIdRs2),
    .stall_count(stallCount), .flush_count(flushCount)
  );

  if_id_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dutWrap (
    .clk(clk), .reset(reset), .hazard_detected(1'b0),
    .ex_branch_taken(1'b0), .ex_branch_target(64'h0),
    .imem_addr(wrapImemAddr), .imem_rdata(imemRdata),
    .if_id_pc(wrapIfIdPc), .if_id_instr(wrapIfIdInstr), .if_id_valid(wrapIfIdValid),
    .if_id_Rs1(wrapRs1), .if_id_Rs2(wrapRs2),
    .stall_count(wrapStallCount), .flush_count(wrapFlushCount)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic haz, input logic br,
                               input logic [63:0] tgt, input logic [31:0] rdata);
    reset          = rst;
    hazardDetected = haz;
    exBranchTaken  = br;
    exBranchTarget = tgt;
    imemRdata      = rdata;
  endtask

  task automatic checkIfId(input string tag, input logic [63:0] addr, input logic [63:0] pc,
                           input logic [31:0] instr, input logic valid);
    checkOutput({tag, ".addr"},  imemAddr,  addr);
    checkOutput({tag, ".pc"},    ifIdPc,    pc);
    checkOutput({tag, ".instr"}, {32'h0, ifIdInstr}, {32'h0, instr});
    checkOutput({tag, ".valid"}, {63'h0, ifIdValid}, {63'h0, valid});
  endtask

  logic [63:0] expAddr[4]  = '{64'd0, 64'd4, 64'd4, 64'd8};
  logic [63:0] expPc[4]    = '{64'd0, 64'd0, 64'd0, 64'd4};
  logic [63:0] expWrap[3]  = '{64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd4};

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 32'h00A00093);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 32'h00A00093);

    // Reset state and free-running fetch, plus wrap-around in the second instance.
    checkIfId("reset", 64'd0, 64'd0, 32'h00000013, 1'b0);
    checkOutput("reset.rs1", {59'h0, ifIdRs1}, 64'd0);
    checkOutput("reset.rs2", {59'h0, ifIdRs2}, 64'd0);
    checkOutput("reset.stallCnt", {32'h0, stallCount}, 64'd0);
    checkOutput("reset.flushCnt", {32'h0, flushCount}, 64'd0);
    checkOutput("wrap0", wrapImemAddr, expWrap[0]);
    for (int i = 1; i < 4; i++) begin
      tick();
      checkOutput($sformatf("run%0d.addr", i), imemAddr, 64'(i * 4));
      checkOutput($sformatf("run%0d.pc", i), ifIdPc, 64'((i - 1) * 4));
      checkOutput($sformatf("run%0d.valid", i), {63'h0, ifIdValid}, 64'd1);
      if (i < 3) checkOutput($sformatf("wrap%0d", i), wrapImemAddr, expWrap[i]);
    end
    checkOutput("run.rs2", {59'h0, ifIdRs2}, 64'd10);

    // Load enters IF/ID, then a 2-cycle stall with junk on imem_rdata.
    imemRdata = 32'h0002A303;
    tick();
    checkIfId("load", 64'd16, 64'd12, 32'h0002A303, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 32'hDEADBEEF);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkIfId($sformatf("stall%0d", i), 64'd16, 64'd12, 32'h0002A303, 1'b1);
      checkOutput($sformatf("stall%0d.rs1", i), {59'h0, ifIdRs1}, 64'd5);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 32'h00B00113);
    tick();
    checkIfId("afterStall", 64'd20, 64'd16, 32'h00B00113, 1'b1);
    checkOutput("stallCnt", {32'h0, stallCount}, PerfOn ? 64'd2 : 64'd0);

    // Advance to pc 0x20, then a taken branch to unaligned target 0x103.
    tick();
    tick();
    tick();
    checkOutput("preBranch.addr", imemAddr, 64'h20);
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h103, 32'h00B00113);
    tick();
    checkIfId("branch", 64'h100, 64'h0, 32'h00000013, 1'b0);
    checkOutput("branch.rs1", {59'h0, ifIdRs1}, 64'd0);
    checkOutput("flushCnt", {32'h0, flushCount}, PerfOn ? 64'd1 : 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 32'h00C00193);
    tick();
    checkIfId("target", 64'h104, 64'h100, 32'h00C00193, 1'b1);

    // Branch and stall together: branch wins and the stall is not counted.
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h200, 32'h00C00193);
    tick();
    checkIfId("brVsStall", 64'h200, 64'h0, 32'h00000013, 1'b0);
    checkOutput("brVsStall.stallCnt", {32'h0, stallCount}, PerfOn ? 64'd2 : 64'd0);
    checkOutput("brVsStall.flushCnt", {32'h0, flushCount}, PerfOn ? 64'd2 : 64'd0);

    // Reset in the middle of a 3-cycle stall.
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 32'h00D00213);
    tick();
    checkIfId("fetch200", 64'h204, 64'h200, 32'h00D00213, 1'b1);
    hazardDetected = 1'b1;
    tick();
    tick();
    checkIfId("midStall", 64'h204, 64'h200, 32'h00D00213, 1'b1);
    checkOutput("midStall.stallCnt", {32'h0, stallCount}, PerfOn ? 64'd4 : 64'd0);
    reset = 1'b1;
    tick();
    checkIfId("rstInStall", 64'd0, 64'd0, 32'h00000013, 1'b0);
    checkOutput("rstInStall.stallCnt", {32'h0, stallCount}, 64'd0);
    checkOutput("rstInStall.flushCnt", {32'h0, flushCount}, 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 32'h00A00093);
    tick();
    checkIfId("postReset", 64'd4, 64'd0, 32'h00A00093, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Fetch stage and IF/ID pipeline register of the 5-stage RISC-V pipeline: holds the 64-bit PC, drives the instruction-memory address, and latches the fetched instruction and its PC into the IF/ID register. It is the direct upstream neighbour of the load-use hazard detection unit: it supplies `if_id_Rs1`/`if_id_Rs2` to it and consumes its `hazard_detected` output as a stall. Taken branches from EX redirect the PC and squash the IF/ID contents.

## Interface
Parameters:
- `RESET_PC`, default 64'h0: PC value loaded on reset.
- `NOP_INSTR`, default 32'h00000013: bubble instruction (`addi x0,x0,0`).
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `hazard_detected`  in  1  stall request from hazard unit.
- `ex_branch_taken`  in  1  taken branch/jump resolved in EX.
- `ex_branch_target`  in  64  redirect address.
- `imem_addr`  out  64  instruction-memory address (combinational read).
- `imem_rdata`  in  32  instruction word for `imem_addr`, same cycle.
- `if_id_pc`  out  64  PC of instruction in IF/ID.
- `if_id_instr`  out  32  instruction in IF/ID.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `if_id_Rs1`  out  5  `if_id_instr[19:15]`.
- `if_id_Rs2`  out  5  `if_id_instr[24:20]`.
- `stall_count`  out  CNT_W  stall-cycle counter (see Configuration).
- `flush_count`  out  CNT_W  flush counter (see Configuration).

## Operation
- `imem_addr` = `pc` combinationally; `if_id_Rs1`/`if_id_Rs2` are pure field slices of `if_id_instr`.
- Per-edge priority: `reset` > `ex_branch_taken` > `hazard_detected` > normal advance.
- Reset: `pc`←`RESET_PC`, `if_id_pc`←0, `if_id_instr`←`NOP_INSTR`, `if_id_valid`←0, counters←0.
- Branch (flush): `pc`←{`ex_branch_target[63:2]`, 2'b00}; `if_id_instr`←`NOP_INSTR`, `if_id_pc`←0, `if_id_valid`←0. Overrides a simultaneous stall; squashing the younger ID/EX instruction is the responsibility of the ID/EX register.
- Stall: `pc`, `if_id_pc`, `if_id_instr`, `if_id_valid` all hold; `imem_rdata` is discarded and refetched next cycle.
- Advance: `if_id_pc`←`pc`, `if_id_instr`←`imem_rdata`, `if_id_valid`←1, `pc`←`pc`+4 modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC wraps to 0).
- Bubble outputs decode to Rs1=Rs2=0; the hazard unit ignores x0 matches, so a bubble never triggers a stall.
- Stall held for N consecutive cycles freezes the stage for exactly N cycles; no instruction lost or duplicated.

## Timing
- Fetch-to-IF/ID latency: 1 cycle (word on `imem_rdata` in cycle t appears on `if_id_instr` after edge t).
- Branch penalty: cycle after `ex_branch_taken`, `imem_addr`=target and IF/ID holds a bubble; target instruction valid in IF/ID one cycle later.
- Hazard path is combinational from `if_id_instr` through hazard unit back to `hazard_detected`; no registered feedback inside this block.
- Reset asserted mid-stall or mid-branch: reset wins on that edge; first fetch from `RESET_PC` on the first cycle after reset deasserts.

## Configuration
- `IFID_PERF_CNT_EN` defined: `stall_count` increments on each edge with `hazard_detected`=1, `ex_branch_taken`=0, `reset`=0; `flush_count` increments on each edge with `ex_branch_taken`=1, `reset`=0. Both saturate at 2^CNT_W−1; cleared by reset.
- Not defined: counter logic not compiled; `stall_count` and `flush_count` are tied to 0; port list unchanged.

## Test plan
- Reset then 4 free-running cycles, imem returns `0x00A00093` at each address -> `imem_addr` 0,4,8,12; `if_id_pc` 0,0,4,8 with `if_id_valid` 0,1,1,1.
- Load `0x0002A303` (lw x6,0(x5)) in IF/ID, assert `hazard_detected` 2 cycles -> `pc`, `if_id_instr`, `if_id_Rs1`=5 hold 2 cycles, then advance by 4; `stall_count`=2 with macro, 0 without.
- `ex_branch_taken`=1, target 0x103 at pc 0x20 -> next cycle `imem_addr`=0x100, `if_id_instr`=0x00000013, `if_id_valid`=0, `flush_count`=1 (macro on).
- Simultaneous `ex_branch_taken` and `hazard_detected` -> branch wins: PC redirected, IF/ID bubbled, `stall_count` unchanged.
- `RESET_PC`=64'hFFFF_FFFF_FFFF_FFFC, advance 2 cycles -> `imem_addr` wraps to 0 then 4.
- Assert `reset` during a 3-cycle stall -> all outputs return to reset values on that edge; counters 0.
